// File: rtl/i2s_pkg.sv
// Shared I2S definitions: channel and sync-state encodings plus the default
// sample width used by both the receive and transmit paths.
package i2s_pkg;

    localparam int unsigned I2S_DATA_WIDTH = 16;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_e;

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } sync_state_e;

endpackage

// File: rtl/i2s_rx_if.sv
// I2S receive bus: serial pins from the external master and parallel stereo
// words back out to the consumer.
interface i2s_rx_if #(
    parameter int unsigned DATA_WIDTH = i2s_pkg::I2S_DATA_WIDTH
) ();

    logic                  i2s_bclk;
    logic                  i2s_lrclk;
    logic                  i2s_din;
    logic [DATA_WIDTH-1:0] left_data;
    logic [DATA_WIDTH-1:0] right_data;
    logic                  data_valid;
    logic                  slot_err;
    logic                  sync_lost;

    modport master (
        output i2s_bclk, i2s_lrclk, i2s_din,
        input  left_data, right_data, data_valid, slot_err, sync_lost
    );

    modport slave (
        input  i2s_bclk, i2s_lrclk, i2s_din,
        output left_data, right_data, data_valid, slot_err, sync_lost
    );

endinterface

// File: rtl/i2s_rx_sync.sv
// Brings the asynchronous I2S pins into the clk domain and flags each BCLK
// rising edge; lrclk_s/din_s are delayed to line up with rise.
module i2s_rx_sync
    import i2s_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic i2s_bclk,
    input  logic i2s_lrclk,
    input  logic i2s_din,
    output logic rise,
    output logic lrclk_s,
    output logic din_s
);

    logic [2:0] bclk_sync_r;
    logic [2:0] lrclk_sync_r;
    logic [2:0] din_sync_r;
    logic       rise_r;

    // Two synchronizer stages plus one alignment stage per pin, registered edge flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync_r  <= 3'b000;
            lrclk_sync_r <= 3'b000;
            din_sync_r   <= 3'b000;
            rise_r       <= 1'b0;
        end else begin
            bclk_sync_r  <= {bclk_sync_r[1:0], i2s_bclk};
            lrclk_sync_r <= {lrclk_sync_r[1:0], i2s_lrclk};
            din_sync_r   <= {din_sync_r[1:0], i2s_din};
            rise_r       <= bclk_sync_r[1] & ~bclk_sync_r[2];
        end
    end

    assign rise    = rise_r;
    assign lrclk_s = lrclk_sync_r[2];
    assign din_s   = din_sync_r[2];

endmodule

// File: rtl/i2s_rx.sv
// Slave-only I2S receiver: deserializes left/right slots MSB-first and emits
// one data_valid pulse per complete left+right frame.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = I2S_DATA_WIDTH,
    parameter int unsigned BCLK_TIMEOUT = 64
) (
    input  logic    clk,
    input  logic    reset_n,
    i2s_rx_if.slave bus
);

    localparam int unsigned           CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam int unsigned           TO_W     = $clog2(BCLK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(BCLK_TIMEOUT - 1);
    localparam logic [TO_W-1:0]       TO_ZERO  = {TO_W{1'b0}};
    localparam logic [DATA_WIDTH-1:0] MSB_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};

    logic                  rise_s;
    logic                  lrclk_s;
    logic                  din_s;
    sync_state_e           state_r;
    sync_state_e           state_next_s;
    ch_e                   prev_lr_r;
    logic                  prev_valid_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [CNT_W-1:0]      cnt_next_s;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] hold_r;
    logic [DATA_WIDTH-1:0] word_s;
    logic [DATA_WIDTH-1:0] bit_mask_s;
    logic                  left_ok_r;
    logic                  left_short_r;
    logic                  short_s;
    logic [TO_W-1:0]       to_cnt_r;
    logic                  boundary_s;
    logic                  timeout_s;
    logic                  frame_done_s;
    logic [DATA_WIDTH-1:0] left_data_r;
    logic [DATA_WIDTH-1:0] right_data_r;
    logic                  data_valid_r;
    logic                  slot_err_r;

    i2s_rx_sync u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .i2s_bclk  (bus.i2s_bclk),
        .i2s_lrclk (bus.i2s_lrclk),
        .i2s_din   (bus.i2s_din),
        .rise      (rise_s),
        .lrclk_s   (lrclk_s),
        .din_s     (din_s)
    );

    // Slot word with the current bit merged in, saturating count and event decode
    always_comb begin
        bit_mask_s = MSB_MASK >> bit_cnt_r;
        word_s     = shift_r;
        cnt_next_s = bit_cnt_r;
        if (din_s) begin
            word_s = shift_r | bit_mask_s;
        end else begin
            word_s = shift_r;
        end
        if (bit_cnt_r == CNT_FULL) begin
            cnt_next_s = bit_cnt_r;
        end else begin
            cnt_next_s = bit_cnt_r + CNT_W'(1);
        end
        short_s      = (cnt_next_s < CNT_FULL);
        boundary_s   = rise_s & prev_valid_r & (ch_e'(lrclk_s) != prev_lr_r);
        timeout_s    = ~rise_s & (to_cnt_r == TO_LAST);
        frame_done_s = boundary_s & (state_r == SYNC) & (prev_lr_r == CH_RIGHT) & left_ok_r;
    end

    // Sync FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= UNSYNC;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sync FSM next state: first boundary locks, BCLK timeout unlocks
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            UNSYNC: begin
                if (boundary_s) begin
                    state_next_s = SYNC;
                end else begin
                    state_next_s = UNSYNC;
                end
            end
            SYNC: begin
                if (timeout_s) begin
                    state_next_s = UNSYNC;
                end else begin
                    state_next_s = SYNC;
                end
            end
            default: state_next_s = UNSYNC;
        endcase
    end

    // Clk cycles since the last rise; a rise always reloads, even on expiry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_r <= TO_ZERO;
        end else if (rise_s) begin
            to_cnt_r <= TO_ZERO;
        end else if (to_cnt_r != TO_LAST) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end

    // Bit shifting, slot closure and left-word holding
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_lr_r    <= CH_LEFT;
            prev_valid_r <= 1'b0;
            bit_cnt_r    <= CNT_ZERO;
            shift_r      <= ZERO_W;
            hold_r       <= ZERO_W;
            left_ok_r    <= 1'b0;
            left_short_r <= 1'b0;
        end else if (timeout_s) begin
            // A stale LRCLK from before the stall must not fake a boundary
            prev_valid_r <= 1'b0;
            bit_cnt_r    <= CNT_ZERO;
            shift_r      <= ZERO_W;
            left_ok_r    <= 1'b0;
        end else if (rise_s) begin
            prev_lr_r    <= ch_e'(lrclk_s);
            prev_valid_r <= 1'b1;
            if (boundary_s) begin
                bit_cnt_r <= CNT_ZERO;
                shift_r   <= ZERO_W;
                // Slots closing while unsynchronised are discarded
                if ((state_r == SYNC) && (prev_lr_r == CH_LEFT)) begin
                    hold_r       <= word_s;
                    left_short_r <= short_s;
                    left_ok_r    <= 1'b1;
                end else if (frame_done_s) begin
                    left_ok_r <= 1'b0;
                end
            end else begin
                bit_cnt_r <= cnt_next_s;
                shift_r   <= word_s;
            end
        end
    end

    // Registered frame outputs; words hold between data_valid pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_data_r  <= ZERO_W;
            right_data_r <= ZERO_W;
            data_valid_r <= 1'b0;
            slot_err_r   <= 1'b0;
        end else begin
            data_valid_r <= frame_done_s;
            slot_err_r   <= frame_done_s & (left_short_r | short_s);
            if (frame_done_s) begin
                left_data_r  <= hold_r;
                right_data_r <= word_s;
            end
        end
    end

    assign bus.left_data  = left_data_r;
    assign bus.right_data = right_data_r;
    assign bus.data_valid = data_valid_r;
    assign bus.slot_err   = slot_err_r;
    assign bus.sync_lost  = (state_r == UNSYNC);

endmodule
